uart_rx_core: RTL and testbench

//  UART receive engine clocked by the oversample tick from the baud timer.
//  - Synchronises the serial line and detects the start bit, then samples each bit at mid-bit.
//  - Checks optional parity and the stop bit(s).
//  - Holds one received word for the APB wrapper in a valid/ready holding register.

---
 rtl/uart_rx_core.sv | 158 +++++++++++++++
 tb/tb_uart_rx_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receive engine: 2-flop line synchroniser, mid-bit sampling on the oversample tick,
// optional parity and stop-bit checks, and a single-word valid/ready holding register.
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = 4;
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DATA   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_STOP   = BW'(STOP_BITS - 1);
    localparam logic          ODD_PAR  = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state, state_d;
    logic                   rx_m, rx_s;
    logic [SW-1:0]          s_cnt;
    logic [BW-1:0]          b_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   perr_r, ferr_r;
    logic                   mid_tick, end_tick, commit_c;

    assign mid_tick = tick && (s_cnt == S_MID);
    assign end_tick = tick && (s_cnt == S_END);
    assign rx_busy  = (state != IDLE);

    // Line synchroniser, resets to the idle (mark) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        commit_c = 1'b0;
        case (state)
            IDLE:   if (!rx_s) state_d = START;
            START:  if (mid_tick) state_d = rx_s ? IDLE : DATA;
            DATA:   if (end_tick && (b_cnt == B_DATA))
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (end_tick) state_d = STOP;
            STOP:   if (end_tick && (b_cnt == B_STOP)) begin
                        state_d  = IDLE;
                        commit_c = 1'b1;
                    end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing, shift register and per-frame error accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt  <= '0;
            b_cnt  <= '0;
            shreg  <= '0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_cnt <= '0;
                    b_cnt <= '0;
                end
                START: if (tick) begin
                    if (mid_tick) begin
                        s_cnt  <= '0;
                        b_cnt  <= '0;
                        perr_r <= 1'b0;
                        ferr_r <= 1'b0;
                    end else begin
                        s_cnt <= s_cnt + SW'(1);
                    end
                end
                DATA, PARITY, STOP: if (tick) begin
                    if (end_tick) begin
                        s_cnt <= '0;
                        if (state == DATA) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            b_cnt <= (b_cnt == B_DATA) ? '0 : b_cnt + BW'(1);
                        end else if (state == PARITY) begin
                            perr_r <= ((^shreg) ^ rx_s) != ODD_PAR;
                            b_cnt  <= '0;
                        end else begin
                            if (!rx_s) ferr_r <= 1'b1;
                            b_cnt <= b_cnt + BW'(1);
                        end
                    end else begin
                        s_cnt <= s_cnt + SW'(1);
                    end
                end
                default: begin
                    s_cnt <= '0;
                    b_cnt <= '0;
                end
            endcase
        end
    end

    // Holding register: a commit wins over a plain read, a full register drops the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit_c) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr_r;
                    frame_err  <= ferr_r | ~rx_s;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E1 instance, directed cases then random frames
// checked against a holding-register model built from the frame contents.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] tcnt = 2'd0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic [7:0] d_a, d_b;
    logic       v_a, v_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b, bz_a, bz_b;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx_a),
        .rx_data(d_a), .rx_valid(v_a), .rx_ready(rdy_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .rx_busy(bz_a)
    );

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_par (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx_b),
        .rx_data(d_b), .rx_valid(v_b), .rx_ready(rdy_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .rx_busy(bz_b)
    );

    always #5 clk = ~clk;

    // Oversample tick every 4 clk
    always @(posedge clk) begin
        tcnt <= tcnt + 2'd1;
        tick <= (tcnt == 2'd3);
    end

    int   total = 0;
    int   bad = 0;
    int   ovr_seen [2] = '{0, 0};
    time  t_start [2];
    time  t_rise [2];
    logic v_prev [2] = '{1'b0, 1'b0};
    event fr_start;

    // Reference model: one held word per instance plus expected overrun count
    logic       hv [2] = '{1'b0, 1'b0};
    logic [7:0] hd [2];
    logic       hp [2], hf [2];
    int         exp_ovr [2] = '{0, 0};

    always @(negedge clk) begin
        if (ov_a) ovr_seen[0]++;
        if (ov_b) ovr_seen[1]++;
        if (v_a && !v_prev[0]) t_rise[0] = $time;
        if (v_b && !v_prev[1]) t_rise[1] = $time;
        v_prev[0] = v_a;
        v_prev[1] = v_b;
    end

    function automatic logic [7:0] get_d(input int sel);
        return (sel == 1) ? d_b : d_a;
    endfunction
    function automatic logic get_v(input int sel);
        return (sel == 1) ? v_b : v_a;
    endfunction
    function automatic logic get_pe(input int sel);
        return (sel == 1) ? pe_b : pe_a;
    endfunction
    function automatic logic get_fe(input int sel);
        return (sel == 1) ? fe_b : fe_a;
    endfunction
    function automatic logic get_bz(input int sel);
        return (sel == 1) ? bz_b : bz_a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic b);
        if (sel == 1) rx_b = b;
        else          rx_a = b;
    endtask

    task automatic set_rdy(input int sel, input logic b);
        if (sel == 1) rdy_b = b;
        else          rdy_a = b;
    endtask

    // One frame on the selected line; a 0 stop bit is held just past its centre only
    task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit, input logic stopv);
        @(negedge clk);
        while (!tick) @(negedge clk);
        t_start[sel] = $time;
        -> fr_start;
        drive(sel, 1'b0);
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            repeat (64) @(negedge clk);
        end
        if (sel == 1) begin
            drive(sel, pbit);
            repeat (64) @(negedge clk);
        end
        drive(sel, stopv);
        repeat (stopv ? 64 : 48) @(negedge clk);
        drive(sel, 1'b1);
        repeat (128) @(negedge clk);
    endtask

    task automatic model_commit(input int sel, input logic [7:0] d, input logic pbit, input logic stopv);
        if (!hv[sel]) begin
            hv[sel] = 1'b1;
            hd[sel] = d;
            hp[sel] = (sel == 1) ? (($countones(d) + int'(pbit)) % 2 == 1) : 1'b0;
            hf[sel] = !stopv;
        end else begin
            exp_ovr[sel]++;
        end
    endtask

    task automatic check_held(input int sel, input string tag);
        chk({tag, "_valid"}, 32'(get_v(sel)), 32'(hv[sel]));
        if (hv[sel]) begin
            chk({tag, "_data"}, 32'(get_d(sel)), 32'(hd[sel]));
            chk({tag, "_perr"}, 32'(get_pe(sel)), 32'(hp[sel]));
            chk({tag, "_ferr"}, 32'(get_fe(sel)), 32'(hf[sel]));
        end
        chk({tag, "_ovr"}, 32'(ovr_seen[sel]), 32'(exp_ovr[sel]));
    endtask

    task automatic consume(input int sel, input string tag);
        @(negedge clk);
        set_rdy(sel, 1'b1);
        @(negedge clk);
        set_rdy(sel, 1'b0);
        hv[sel] = 1'b0;
        chk({tag, "_drop"}, 32'(get_v(sel)), 32'd0);
    endtask

    task automatic check_reset(input int sel, input string tag);
        chk({tag, "_valid"}, 32'(get_v(sel)), 32'd0);
        chk({tag, "_data"}, 32'(get_d(sel)), 32'd0);
        chk({tag, "_perr"}, 32'(get_pe(sel)), 32'd0);
        chk({tag, "_ferr"}, 32'(get_fe(sel)), 32'd0);
        chk({tag, "_busy"}, 32'(get_bz(sel)), 32'd0);
    endtask

    initial begin
        time        lat;
        int         n;
        int         sel;
        logic [7:0] d;
        logic       pbit, stopv;

        repeat (3) @(negedge clk);
        check_reset(0, "rst_a");
        check_reset(1, "rst_b");
        chk("rst_ovr", 32'(ovr_seen[0] + ovr_seen[1]), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // 8N1 0x55, read on the first valid cycle
        fork
            send_frame(0, 8'h55, 1'b0, 1'b1);
            begin
                n = 0;
                while (!v_a && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                chk("t1_timeout", 32'(n < 3000), 32'd1);
                chk("t1_data", 32'(d_a), 32'h55);
                chk("t1_perr", 32'(pe_a), 32'd0);
                chk("t1_ferr", 32'(fe_a), 32'd0);
                rdy_a = 1'b1;
                @(negedge clk);
                rdy_a = 1'b0;
                chk("t1_one_cycle", 32'(v_a), 32'd0);
            end
        join
        lat = t_rise[0] - t_start[0];

        // False start: low for 3 ticks
        @(negedge clk);
        while (!tick) @(negedge clk);
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_busy_hi", 32'(bz_a), 32'd1);
        repeat (8) @(negedge clk);
        rx_a = 1'b1;
        repeat (100) @(negedge clk);
        chk("t2_busy_lo", 32'(bz_a), 32'd0);
        chk("t2_valid", 32'(v_a), 32'd0);
        chk("t2_ovr", 32'(ovr_seen[0]), 32'd0);

        // Bad stop bit
        send_frame(0, 8'hA3, 1'b0, 1'b0);
        model_commit(0, 8'hA3, 1'b0, 1'b0);
        check_held(0, "t3");
        consume(0, "t3");

        // Even parity on 0x0F: wrong then right parity bit
        send_frame(1, 8'h0F, 1'b1, 1'b1);
        model_commit(1, 8'h0F, 1'b1, 1'b1);
        check_held(1, "t4a");
        chk("t4a_perr_abs", 32'(pe_b), 32'd1);
        consume(1, "t4a");
        send_frame(1, 8'h0F, 1'b0, 1'b1);
        model_commit(1, 8'h0F, 1'b0, 1'b1);
        check_held(1, "t4b");
        chk("t4b_perr_abs", 32'(pe_b), 32'd0);
        consume(1, "t4b");

        // Overrun with the holding register full
        send_frame(0, 8'h11, 1'b0, 1'b1);
        model_commit(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        model_commit(0, 8'h22, 1'b0, 1'b1);
        check_held(0, "t5a");
        chk("t5a_data_abs", 32'(d_a), 32'h11);

        // Read coinciding with the commit edge: new word replaces old, no overrun
        fork
            send_frame(0, 8'h33, 1'b0, 1'b1);
            begin
                @(fr_start);
                #(lat - 10);
                rdy_a = 1'b1;
                #10;
                rdy_a = 1'b0;
            end
        join
        hv[0] = 1'b0;
        model_commit(0, 8'h33, 1'b0, 1'b1);
        check_held(0, "t5b");
        consume(0, "t5b");

        // Reset in the middle of a frame
        @(negedge clk);
        while (!tick) @(negedge clk);
        rx_a = 1'b0;
        repeat (164) @(negedge clk);
        chk("t6_busy_pre", 32'(bz_a), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset(0, "t6_rst");
        chk("t6_rst_ovr", 32'(ov_a), 32'd0);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hv[0] = 1'b0;
        repeat (50) @(negedge clk);
        send_frame(0, 8'hC3, 1'b0, 1'b1);
        model_commit(0, 8'hC3, 1'b0, 1'b1);
        check_held(0, "t6");
        consume(0, "t6");

        // Random frames on both instances; reads skipped sometimes to provoke overruns
        for (int k = 0; k < 30; k++) begin
            sel   = int'($urandom_range(0, 1));
            d     = 8'($urandom);
            pbit  = 1'($urandom_range(0, 1));
            stopv = ($urandom_range(0, 3) != 0);
            send_frame(sel, d, pbit, stopv);
            model_commit(sel, d, pbit, stopv);
            check_held(sel, "rnd");
            if (hv[sel] && $urandom_range(0, 3) != 0) consume(sel, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
